// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Provides a combinational next-PC prediction for the fetch stage, is trained
// by resolved branches from EX/MEM, and reports mispredictions with the
// recovery PC plus saturating performance counters.
module branch_target_predictor #(
    parameter int unsigned ENTRIES   = 16,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter logic [1:0]  ALLOC_CTR = 2'b10,
    parameter int unsigned STAT_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_next_pc,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic [31:0]       upd_pred_next,
    output logic              mispredict,
    output logic [31:0]       recover_pc,
    input  logic              flush_all,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    // Table state
    logic              valid_q [ENTRIES];
    logic              valid_d [ENTRIES];
    logic [1:0]        ctr_q   [ENTRIES];
    logic [1:0]        ctr_d   [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [TAG_W-1:0]  tag_d   [ENTRIES];
    logic [31:0]       tgt_q   [ENTRIES];
    logic [31:0]       tgt_d   [ENTRIES];

    // Performance counters
    logic [STAT_W-1:0] stat_branches_q;
    logic [STAT_W-1:0] stat_branches_d;
    logic [STAT_W-1:0] stat_mispredicts_q;
    logic [STAT_W-1:0] stat_mispredicts_d;

    // Address decomposition
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic [31:0]       lk_fallthru;
    logic [31:0]       up_fallthru;
    logic [31:0]       actual_next;
    logic              up_hit;
    logic              mispredict_int;
    logic              unused_pc_lsbs;

    assign lk_idx      = lookup_pc[IDX_W+1:2];
    assign lk_tag      = lookup_pc[31:IDX_W+2];
    assign up_idx      = upd_pc[IDX_W+1:2];
    assign up_tag      = upd_pc[31:IDX_W+2];
    assign lk_fallthru = lookup_pc + 32'd4;
    assign up_fallthru = upd_pc + 32'd4;

    // Byte offset within a word never participates in indexing or tagging
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Fetch-side prediction from registered table state (no update bypass)
    always_comb begin
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && ctr_q[lk_idx][1];
        pred_next_pc = pred_taken ? tgt_q[lk_idx] : lk_fallthru;
    end

    // Resolution-side misprediction detection and recovery PC
    always_comb begin
        actual_next    = upd_taken ? upd_target : up_fallthru;
        up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        mispredict_int = upd_valid && (actual_next != upd_pred_next);
        mispredict     = mispredict_int;
        recover_pc     = upd_valid ? actual_next : 32'd0;
    end

    // Next table state: training, allocation and bulk invalidate
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_d[i] = valid_q[i];
            ctr_d[i]   = ctr_q[i];
            tag_d[i]   = tag_q[i];
            tgt_d[i]   = tgt_q[i];
        end

        if (flush_all) begin
            // Only the valid bits are cleared; counters and targets persist
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    tgt_d[up_idx] = upd_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Direct-mapped allocation evicts whatever lived at this index
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = upd_target;
                ctr_d[up_idx]   = ALLOC_CTR;
            end
        end
    end

    // Next statistics: saturating event counters, flush does not suppress counting
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_valid && (stat_branches_q != {STAT_W{1'b1}})) begin
            stat_branches_d = stat_branches_q + STAT_W'(1);
        end
        if (mispredict_int && (stat_mispredicts_q != {STAT_W{1'b1}})) begin
            stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
        end
    end

    // Table registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
                tag_q[i]   <= '0;
                tgt_q[i]   <= 32'd0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= valid_d[i];
                ctr_q[i]   <= ctr_d[i];
                tag_q[i]   <= tag_d[i];
                tgt_q[i]   <= tgt_d[i];
            end
        end
    end

    // Statistics registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expectations are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_branch_target_predictor;

    localparam int unsigned STAT_W  = 4;
    localparam int unsigned STAT_MX = 15;

    logic              CLK;
    logic              RST;
    logic [31:0]       lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [31:0]       pred_next_pc;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic [31:0]       upd_pred_next;
    logic              mispredict;
    logic [31:0]       recover_pc;
    logic              flush_all;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    branch_target_predictor #(
        .ENTRIES  (16),
        .CTR_INIT (2'b01),
        .ALLOC_CTR(2'b10),
        .STAT_W   (STAT_W)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .lookup_pc       (lookup_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_next_pc    (pred_next_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_next   (upd_pred_next),
        .mispredict      (mispredict),
        .recover_pc      (recover_pc),
        .flush_all       (flush_all),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int br_m  = 0;
    int mp_m  = 0;

    string       tag_sb [$];
    logic [31:0] exp_sb [$];

    // Queue an expected value for a later sample
    task automatic expect_val(input string t, input logic [31:0] v);
        tag_sb.push_back(t);
        exp_sb.push_back(v);
    endtask

    // Pop the oldest expectation and compare it against an observed output
    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        tests++;
        if (exp_sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            t = tag_sb.pop_front();
            e = exp_sb.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    // Drive a resolution packet
    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] pn);
        upd_valid     = v;
        upd_pc        = pc;
        upd_taken     = tk;
        upd_target    = tgt;
        upd_pred_next = pn;
    endtask

    // Advance one clock, updating the saturating stat model from the driven inputs
    task automatic tick();
        logic [31:0] act;
        act = upd_taken ? upd_target : (upd_pc + 32'd4);
        if (upd_valid && !RST) begin
            if (br_m != STAT_MX) br_m++;
            if ((act != upd_pred_next) && (mp_m != STAT_MX)) mp_m++;
        end
        @(posedge CLK);
        #1;
    endtask

    // Queue and check both statistics against the model
    task automatic chk_stats(input string t);
        expect_val({t, "_branches"}, 32'(br_m));
        expect_val({t, "_mispredicts"}, 32'(mp_m));
        chk(32'(stat_branches));
        chk(32'(stat_mispredicts));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        lookup_pc = 32'h0;
        flush_all = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #12;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Reset state
        lookup_pc = 32'h40;
        #1;
        expect_val("rst_hit", 32'd0);     chk(32'(pred_hit));
        expect_val("rst_taken", 32'd0);   chk(32'(pred_taken));
        expect_val("rst_next", 32'h44);   chk(pred_next_pc);
        expect_val("rst_misp", 32'd0);    chk(32'(mispredict));
        expect_val("rst_recover", 32'd0); chk(recover_pc);
        chk_stats("rst");

        // Allocate 0x40 taken to 0x100 while predicted fall-through
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 32'h44);
        #1;
        expect_val("alloc_misp", 32'd1);      chk(32'(mispredict));
        expect_val("alloc_recover", 32'h100); chk(recover_pc);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        expect_val("alloc_hit", 32'd1);    chk(32'(pred_hit));
        expect_val("alloc_taken", 32'd1);  chk(32'(pred_taken));
        expect_val("alloc_next", 32'h100); chk(pred_next_pc);
        chk_stats("alloc");

        // Three not-taken updates drive the counter 2->1->0->0
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 32'h100);
        tick();
        #1;
        expect_val("nt1_taken", 32'd0); chk(32'(pred_taken));
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 32'h44);
        #1;
        expect_val("nt2_misp", 32'd0);      chk(32'(mispredict));
        expect_val("nt2_recover", 32'h44);  chk(recover_pc);
        tick();
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        expect_val("nt_hit", 32'd1);   chk(32'(pred_hit));
        expect_val("nt_taken", 32'd0); chk(32'(pred_taken));
        expect_val("nt_next", 32'h44); chk(pred_next_pc);
        chk_stats("nt");

        // Conflicting allocation at the same index evicts 0x40
        set_upd(1'b1, 32'h80, 1'b1, 32'h200, 32'h84);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        expect_val("evict_old_hit", 32'd0); chk(32'(pred_hit));
        lookup_pc = 32'h80;
        #1;
        expect_val("evict_new_hit", 32'd1);    chk(32'(pred_hit));
        expect_val("evict_new_next", 32'h200); chk(pred_next_pc);

        // Re-allocate 0x40, then update and look it up in the same cycle
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 32'h44);
        tick();
        lookup_pc = 32'h40;
        set_upd(1'b1, 32'h40, 1'b1, 32'h300, 32'h100);
        #1;
        expect_val("same_cycle_old", 32'h100); chk(pred_next_pc);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        expect_val("same_cycle_new", 32'h300); chk(pred_next_pc);

        // Fall-through arithmetic wraps modulo 2^32
        lookup_pc = 32'hFFFF_FFFC;
        set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        #1;
        expect_val("wrap_next", 32'h0);    chk(pred_next_pc);
        expect_val("wrap_recover", 32'h0); chk(recover_pc);
        expect_val("wrap_misp", 32'd0);    chk(32'(mispredict));
        tick();

        // Flush with a simultaneous update: table invalidated, update still counted
        flush_all = 1'b1;
        set_upd(1'b1, 32'h80, 1'b1, 32'h400, 32'h200);
        tick();
        flush_all = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        lookup_pc = 32'h40;
        #1;
        expect_val("flush_hit40", 32'd0); chk(32'(pred_hit));
        lookup_pc = 32'h80;
        #1;
        expect_val("flush_hit80", 32'd0); chk(32'(pred_hit));
        chk_stats("flush");

        // Asynchronous reset between edges while an allocation is pending
        lookup_pc = 32'hC0;
        set_upd(1'b1, 32'hC0, 1'b1, 32'h500, 32'hC4);
        #2;
        RST  = 1'b1;
        br_m = 0;
        mp_m = 0;
        #1;
        chk_stats("async_rst");
        expect_val("async_rst_hit", 32'd0); chk(32'(pred_hit));
        @(posedge CLK);
        #1;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        expect_val("no_alloc_hit", 32'd0);    chk(32'(pred_hit));
        expect_val("no_alloc_next", 32'hC4);  chk(pred_next_pc);
        chk_stats("post_rst");

        // Twenty correctly predicted updates saturate the 4-bit branch counter
        set_upd(1'b1, 32'h100, 1'b0, 32'h0, 32'h104);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        expect_val("sat_branches_raw", 32'd15); chk(32'(stat_branches));
        chk_stats("sat");
        expect_val("idle_misp", 32'd0);    chk(32'(mispredict));
        expect_val("idle_recover", 32'd0); chk(recover_pc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
